// File: rtl/dpll_trail_stack.sv
// dpll_trail_stack
//   Decision-trail stack for the DPLL SAT core. Each entry keeps a formula
//   snapshot, the decision literal (id + polarity) and a "flipped" flag that
//   marks entries whose second branch is already being explored. Supports
//   PUSH / POP / FLIP_TOP and an autonomous BACKTRACK that pops flipped
//   entries until it finds an unflipped one (flips it) or runs out (UNSAT).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | accepting commands, op_ready=1
//   BT_SCAN | BACKTRACK in progress, one top-of-stack inspection per cycle
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   flush                empty the stack and clear error flags (beats op_valid)
//   op_valid/op_ready    command handshake; op_ready=1 only in IDLE
//   op_code              0 PUSH, 1 POP, 2 FLIP_TOP, 3 BACKTRACK
//   push_formula/lit_*   entry contents for PUSH
//   top_*                combinational view of entry[count-1] (zeros when empty)
//   count, full, empty   occupancy
//   bt_done, bt_unsat    one-cycle BACKTRACK completion pulse and its verdict
//   err_overflow/err_underflow  sticky error flags
module dpll_trail_stack #(
  parameter int NUM_CLAUSES  = 5,
  parameter int NUM_LITERALS = 3,
  parameter int DEPTH        = NUM_LITERALS,
  parameter int LIT_W        = $clog2(NUM_LITERALS + 1),
  parameter int FLEN_W       = $clog2(NUM_CLAUSES + 1),
  parameter int CNT_W        = $clog2(DEPTH + 1),
  parameter int FORM_W       = NUM_CLAUSES * (NUM_LITERALS * (LIT_W + 1) + LIT_W) + FLEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [FORM_W-1:0] push_formula,
  input  logic [LIT_W-1:0]  push_lit_num,
  input  logic              push_lit_val,
  output logic              top_valid,
  output logic [FORM_W-1:0] top_formula,
  output logic [LIT_W-1:0]  top_lit_num,
  output logic              top_lit_val,
  output logic              top_flipped,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              bt_done,
  output logic              bt_unsat,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam logic [1:0] OP_PUSH      = 2'd0;
  localparam logic [1:0] OP_POP       = 2'd1;
  localparam logic [1:0] OP_FLIP_TOP  = 2'd2;
  localparam logic [1:0] OP_BACKTRACK = 2'd3;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    BT_SCAN = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             bt_done_q, bt_done_d;
  logic             bt_unsat_q, bt_unsat_d;
  logic             err_ov_q, err_ov_d;
  logic             err_un_q, err_un_d;

  // Entry storage is deliberately not reset; count_q alone defines validity.
  logic [FORM_W-1:0] formula_q [DEPTH];
  logic [LIT_W-1:0]  lit_num_q [DEPTH];
  logic              lit_val_q [DEPTH];
  logic              flipped_q [DEPTH];

  logic             wr_push;
  logic             wr_flip;
  logic             op_fire;
  logic             is_empty;
  logic             is_full;
  logic [CNT_W-1:0] top_idx;
  logic             top_flipped_raw;
  logic             top_lit_val_raw;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  // Wraps when empty; every consumer is gated by is_empty.
  assign top_idx  = count_q - ONE_C;
  assign op_fire  = op_valid && (state_q == IDLE);

  assign top_flipped_raw = flipped_q[top_idx];
  assign top_lit_val_raw = lit_val_q[top_idx];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bt_done_d  = 1'b0;
    bt_unsat_d = 1'b0;
    err_ov_d   = err_ov_q;
    err_un_d   = err_un_q;
    wr_push    = 1'b0;
    wr_flip    = 1'b0;

    if (flush) begin
      // Also aborts a running BACKTRACK without a completion pulse.
      state_d  = IDLE;
      count_d  = '0;
      err_ov_d = 1'b0;
      err_un_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (op_fire) begin
            unique case (op_code)
              OP_PUSH: begin
                if (is_full) begin
                  err_ov_d = 1'b1;
                end else begin
                  wr_push = 1'b1;
                  count_d = count_q + ONE_C;
                end
              end
              OP_POP: begin
                if (is_empty) err_un_d = 1'b1;
                else          count_d  = count_q - ONE_C;
              end
              OP_FLIP_TOP: begin
                if (is_empty) err_un_d = 1'b1;
                else          wr_flip  = 1'b1;
              end
              OP_BACKTRACK: begin
                state_d = BT_SCAN;
              end
              default: ;
            endcase
          end
        end
        BT_SCAN: begin
          if (is_empty) begin
            bt_done_d  = 1'b1;
            bt_unsat_d = 1'b1;
            state_d    = IDLE;
          end else if (top_flipped_raw) begin
            count_d = count_q - ONE_C;
          end else begin
            wr_flip   = 1'b1;
            bt_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      bt_done_q  <= 1'b0;
      bt_unsat_q <= 1'b0;
      err_ov_q   <= 1'b0;
      err_un_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      bt_done_q  <= bt_done_d;
      bt_unsat_q <= bt_unsat_d;
      err_ov_q   <= err_ov_d;
      err_un_q   <= err_un_d;
    end
  end

  // wr_* are forced low by rst only through the FSM; gate here too so a
  // command presented during reset cannot corrupt storage.
  always_ff @(posedge clk) begin
    if (!rst && wr_push) begin
      formula_q[count_q] <= push_formula;
      lit_num_q[count_q] <= push_lit_num;
      lit_val_q[count_q] <= push_lit_val;
      flipped_q[count_q] <= 1'b0;
    end else if (!rst && wr_flip) begin
      lit_val_q[top_idx] <= ~top_lit_val_raw;
      flipped_q[top_idx] <= 1'b1;
    end
  end

  assign op_ready      = (state_q == IDLE);
  assign top_valid     = !is_empty;
  assign top_formula   = is_empty ? '0   : formula_q[top_idx];
  assign top_lit_num   = is_empty ? '0   : lit_num_q[top_idx];
  assign top_lit_val   = is_empty ? 1'b0 : top_lit_val_raw;
  assign top_flipped   = is_empty ? 1'b0 : top_flipped_raw;
  assign count         = count_q;
  assign full          = full_q;
  assign empty         = empty_q;
  assign bt_done       = bt_done_q;
  assign bt_unsat      = bt_unsat_q;
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;

endmodule

// File: tb/tb_dpll_trail_stack.sv
module tb_dpll_trail_stack;

  localparam int FORM_W = 58;
  localparam int LIT_W  = 2;
  localparam int CNT_W  = 2;

  localparam logic [1:0] PUSH = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] FLIP = 2'd2;
  localparam logic [1:0] BT   = 2'd3;

  localparam logic [FORM_W-1:0] F1 = 58'h0123_4567_89AB_CDE;
  localparam logic [FORM_W-1:0] F2 = 58'h3FF_0000_FFFF_0000;
  localparam logic [FORM_W-1:0] F3 = 58'h2A_5A5A_5A5A_5A5A;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [1:0]        op_code = 2'd0;
  logic [FORM_W-1:0] push_formula = '0;
  logic [LIT_W-1:0]  push_lit_num = '0;
  logic              push_lit_val = 1'b0;
  logic              top_valid;
  logic [FORM_W-1:0] top_formula;
  logic [LIT_W-1:0]  top_lit_num;
  logic              top_lit_val;
  logic              top_flipped;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              bt_done;
  logic              bt_unsat;
  logic              err_overflow;
  logic              err_underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dpll_trail_stack dut (
    .clk(clk), .rst(rst), .flush(flush),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .push_formula(push_formula), .push_lit_num(push_lit_num), .push_lit_val(push_lit_val),
    .top_valid(top_valid), .top_formula(top_formula), .top_lit_num(top_lit_num),
    .top_lit_val(top_lit_val), .top_flipped(top_flipped),
    .count(count), .full(full), .empty(empty),
    .bt_done(bt_done), .bt_unsat(bt_unsat),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for one cycle; on return the post-edge state is visible.
  task automatic cmd(input logic [1:0] op, input logic [FORM_W-1:0] f,
                     input logic [LIT_W-1:0] ln, input logic lv);
    op_valid     = 1'b1;
    op_code      = op;
    push_formula = f;
    push_lit_num = ln;
    push_lit_val = lv;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_top_valid", 64'(top_valid), 64'd0);
    chk("rst_top_formula", 64'(top_formula), 64'd0);
    chk("rst_op_ready", 64'(op_ready), 64'd1);
    chk("rst_errs", 64'({err_overflow, err_underflow, bt_done}), 64'd0);

    // 1: three pushes fill the stack
    cmd(PUSH, F1, 2'd1, 1'b0);
    chk("p1_count", 64'(count), 64'd1);
    chk("p1_top_formula", 64'(top_formula), 64'(F1));
    cmd(PUSH, F2, 2'd2, 1'b1);
    chk("p2_top_lit_val", 64'(top_lit_val), 64'd1);
    cmd(PUSH, F3, 2'd3, 1'b0);
    chk("p3_count", 64'(count), 64'd3);
    chk("p3_full", 64'(full), 64'd1);
    chk("p3_top_lit_num", 64'(top_lit_num), 64'd3);
    chk("p3_top_flipped", 64'(top_flipped), 64'd0);
    chk("p3_top_formula", 64'(top_formula), 64'(F3));

    // 2: overflow, then flush
    cmd(PUSH, F1, 2'd1, 1'b1);
    chk("ovf_count", 64'(count), 64'd3);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_top_lit_num", 64'(top_lit_num), 64'd3);
    chk("ovf_top_formula", 64'(top_formula), 64'(F3));
    do_flush();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_err", 64'(err_overflow), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);

    // 3: build {unflipped, flipped, flipped}, then BACKTRACK
    cmd(PUSH, F1, 2'd1, 1'b0);
    cmd(PUSH, F2, 2'd2, 1'b1);
    cmd(FLIP, '0, 2'd0, 1'b0);
    chk("flip_flipped", 64'(top_flipped), 64'd1);
    chk("flip_lit_val", 64'(top_lit_val), 64'd0);
    cmd(PUSH, F3, 2'd3, 1'b0);
    cmd(FLIP, '0, 2'd0, 1'b0);
    chk("flip2_lit_val", 64'(top_lit_val), 64'd1);
    cmd(BT, '0, 2'd0, 1'b0);              // T+1
    chk("bt_t1_ready", 64'(op_ready), 64'd0);
    chk("bt_t1_count", 64'(count), 64'd3);
    tick();                               // T+2
    chk("bt_t2_count", 64'(count), 64'd2);
    chk("bt_t2_ready", 64'(op_ready), 64'd0);
    tick();                               // T+3
    chk("bt_t3_count", 64'(count), 64'd1);
    chk("bt_t3_ready", 64'(op_ready), 64'd0);
    chk("bt_t3_done", 64'(bt_done), 64'd0);
    tick();                               // T+4
    chk("bt_t4_done", 64'(bt_done), 64'd1);
    chk("bt_t4_unsat", 64'(bt_unsat), 64'd0);
    chk("bt_t4_count", 64'(count), 64'd1);
    chk("bt_t4_ready", 64'(op_ready), 64'd1);
    chk("bt_t4_flipped", 64'(top_flipped), 64'd1);
    chk("bt_t4_lit_val", 64'(top_lit_val), 64'd1);
    chk("bt_t4_lit_num", 64'(top_lit_num), 64'd1);
    tick();
    chk("bt_t5_done", 64'(bt_done), 64'd0);

    // 4: all flipped, count 2 -> UNSAT
    cmd(PUSH, F2, 2'd2, 1'b1);
    cmd(FLIP, '0, 2'd0, 1'b0);
    chk("u_count", 64'(count), 64'd2);
    cmd(BT, '0, 2'd0, 1'b0);              // T+1
    tick();                               // T+2
    chk("u_t2_count", 64'(count), 64'd1);
    tick();                               // T+3
    chk("u_t3_count", 64'(count), 64'd0);
    chk("u_t3_done", 64'(bt_done), 64'd0);
    tick();                               // T+4
    chk("u_t4_done", 64'(bt_done), 64'd1);
    chk("u_t4_unsat", 64'(bt_unsat), 64'd1);
    chk("u_t4_empty", 64'(empty), 64'd1);
    chk("u_t4_underflow", 64'(err_underflow), 64'd0);

    // 5: underflow is sticky but does not block
    cmd(POP, '0, 2'd0, 1'b0);
    chk("unf_flag", 64'(err_underflow), 64'd1);
    chk("unf_count", 64'(count), 64'd0);
    cmd(PUSH, F1, 2'd1, 1'b0);
    chk("unf_push_count", 64'(count), 64'd1);
    chk("unf_push_formula", 64'(top_formula), 64'(F1));
    chk("unf_sticky", 64'(err_underflow), 64'd1);
    cmd(POP, '0, 2'd0, 1'b0);
    chk("pop_count", 64'(count), 64'd0);

    // BACKTRACK on empty stack -> UNSAT at T+2, no error flag
    do_flush();
    chk("ef_underflow", 64'(err_underflow), 64'd0);
    cmd(BT, '0, 2'd0, 1'b0);              // T+1
    chk("e_t1_done", 64'(bt_done), 64'd0);
    tick();                               // T+2
    chk("e_t2_done", 64'(bt_done), 64'd1);
    chk("e_t2_unsat", 64'(bt_unsat), 64'd1);
    chk("e_t2_ready", 64'(op_ready), 64'd1);
    chk("e_t2_underflow", 64'(err_underflow), 64'd0);

    // 6: flush with PUSH mid-BT_SCAN aborts
    cmd(PUSH, F1, 2'd1, 1'b0);
    cmd(FLIP, '0, 2'd0, 1'b0);
    cmd(PUSH, F2, 2'd2, 1'b0);
    cmd(FLIP, '0, 2'd0, 1'b0);
    cmd(PUSH, F3, 2'd3, 1'b0);
    cmd(FLIP, '0, 2'd0, 1'b0);
    chk("a_count", 64'(count), 64'd3);
    cmd(BT, '0, 2'd0, 1'b0);              // T+1, scanning
    flush        = 1'b1;
    op_valid     = 1'b1;
    op_code      = PUSH;
    push_formula = F2;
    push_lit_num = 2'd2;
    tick();                               // T+2
    flush    = 1'b0;
    op_valid = 1'b0;
    chk("a_count0", 64'(count), 64'd0);
    chk("a_ready", 64'(op_ready), 64'd1);
    chk("a_done", 64'(bt_done), 64'd0);
    tick();
    chk("a_count1", 64'(count), 64'd0);
    chk("a_done1", 64'(bt_done), 64'd0);
    tick();
    chk("a_done2", 64'(bt_done), 64'd0);
    chk("a_empty", 64'(empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
